// File: rtl/width_down_converter.sv
// Width down-converter: splits each IN_WIDTH word into IN_WIDTH/OUT_WIDTH OUT_WIDTH beats.
// Define WIDTH_DOWN_CONVERTER_MSB_FIRST_EN to emit the most-significant slice first.
module width_down_converter #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned Ratio = (OUT_WIDTH == 0) ? 1 : IN_WIDTH / OUT_WIDTH;
  localparam int unsigned BeatW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

  if (OUT_WIDTH < 1 || IN_WIDTH < OUT_WIDTH || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_cfg
    $error("width_down_converter: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic                loaded_q, loaded_d;
  logic                accept, xfer;

  assign out_valid = loaded_q;
  assign busy      = loaded_q;
  assign out_last  = loaded_q && (beat_q == LastBeat);
  assign in_ready  = !loaded_q || (out_last && out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = loaded_q && out_ready;

`ifdef WIDTH_DOWN_CONVERTER_MSB_FIRST_EN
  assign out_data = hold_q[IN_WIDTH-1 -: OUT_WIDTH];
`else
  assign out_data = hold_q[OUT_WIDTH-1:0];
`endif

  always_comb begin
    hold_d   = hold_q;
    beat_d   = beat_q;
    loaded_d = loaded_q;
    // A new word arriving on the last-beat edge takes priority over the unload.
    if (accept) begin
      hold_d   = in_data;
      beat_d   = '0;
      loaded_d = 1'b1;
    end else if (xfer) begin
      if (out_last) begin
        beat_d   = '0;
        loaded_d = 1'b0;
      end else begin
`ifdef WIDTH_DOWN_CONVERTER_MSB_FIRST_EN
        hold_d = hold_q << OUT_WIDTH;
`else
        hold_d = hold_q >> OUT_WIDTH;
`endif
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      beat_q   <= '0;
      loaded_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      beat_q   <= beat_d;
      loaded_q <= loaded_d;
    end
  end

endmodule

// File: tb/tb_width_down_converter.sv
// Bench for width_down_converter: directed cases plus random traffic against a queue-of-beats
// model, and a 32->8 instance for the wider ratio.
module tb_width_down_converter;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 8;
  localparam int unsigned R  = IW / OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;

  logic [31:0]   in_data32 = '0;
  logic          in_valid32 = 1'b0;
  logic          in_ready32;
  logic [7:0]    out_data32;
  logic          out_valid32;
  logic          out_ready32 = 1'b0;
  logic          out_last32;
  logic          busy32;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];  // beats still owed for the word currently held

  always #5 clk = ~clk;

  width_down_converter #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
  );

  width_down_converter #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data32), .in_valid(in_valid32),
    .in_ready(in_ready32), .out_data(out_data32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_last(out_last32), .busy(busy32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] slice(input logic [IW-1:0] w, input int i);
`ifdef WIDTH_DOWN_CONVERTER_MSB_FIRST_EN
    return OW'(w >> ((R - 1 - i) * OW));
`else
    return OW'(w >> (i * OW));
`endif
  endfunction

  // Check outputs mid-cycle, then advance one edge and update the model.
  task automatic step(input string tag);
    logic acc, xf, exp_rdy;
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_q.size() != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (exp_q.size() != 0) begin
      chk({tag, ".data"}, 32'(out_data), 32'(exp_q[0]));
      chk({tag, ".last"}, 32'(out_last), 32'(exp_q.size() == 1));
    end else begin
      chk({tag, ".last_idle"}, 32'(out_last), 32'd0);
    end
    acc = in_valid && exp_rdy;
    xf  = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (xf) void'(exp_q.pop_front());
    if (acc) for (int i = 0; i < int'(R); i++) exp_q.push_back(slice(in_data, i));
    #1;
  endtask

  initial begin
    #2;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.data", 32'(out_data), 32'd0);
    chk("reset.last", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Single word, consumer always ready.
    out_ready = 1'b1; in_data = 16'hA55A; in_valid = 1'b1;
    step("one.acc");
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("one");

    // Back-to-back words with in_valid held high.
    in_valid = 1'b1; in_data = 16'h1234;
    step("b2b.acc0");
    in_data = 16'h5678;
    step("b2b.hold");
    step("b2b.acc1");
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("b2b");

    // Output stall with an ignored in_valid.
    in_data = 16'hBEEF; in_valid = 1'b1;
    step("stall.acc");
    in_valid = 1'b0;
    step("stall.b0");
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
    for (int i = 0; i < 3; i++) step("stall.wait");
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) step("stall.rel");

    // Reset after the first beat of a word.
    in_data = 16'hCAFE; in_valid = 1'b1;
    step("rst.acc");
    in_valid = 1'b0;
    step("rst.b0");
    rst_n = 1'b0;
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step("rst.after");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = IW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step("rand");
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < int'(R) + 1; i++) step("drain");

    // 32->8 instance, LSB slice first by default.
`ifndef WIDTH_DOWN_CONVERTER_MSB_FIRST_EN
    out_ready32 = 1'b1; in_data32 = 32'h04030201; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("w32.valid", 32'(out_valid32), 32'd1);
      chk("w32.data", 32'(out_data32), 32'(k + 1));
      chk("w32.last", 32'(out_last32), 32'(k == 3));
      @(posedge clk); #1;
    end
    chk("w32.idle", 32'(out_valid32), 32'd0);
    chk("w32.in_ready", 32'(in_ready32), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
